// File: rtl/ysyx_23060236_wbu.sv
// Writeback stage: registers one completed instruction per cycle, aligns load data,
// drives the register-file write port, counts retirements and halts on ebreak.
// Optional decode bypass outputs are enabled by defining YSYX_23060236_WBU_FWD_EN.
module ysyx_23060236_wbu #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32   // load alignment below assumes 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_wen,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic [1:0]            in_addr_lo,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic [DATA_WIDTH-1:0] in_load_word,
  input  logic                  in_ebreak,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic                  rf_wen,
  output logic                  rf_valid,
  output logic [31:0]           retire_cnt,
  output logic                  halted,
  output logic                  fwd_valid,
  output logic [ADDR_WIDTH-1:0] fwd_addr,
  output logic [DATA_WIDTH-1:0] fwd_data
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic                  full_q;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic                  wen_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [31:0]           retire_q;

  logic                  transfer;
  logic [DATA_WIDTH-1:0] result;

  // Shift the addressed byte/halfword down to bit 0, then extend per funct3.
  function automatic logic [DATA_WIDTH-1:0] align_load(
    input logic [2:0]            funct3,
    input logic [1:0]            addr_lo,
    input logic [DATA_WIDTH-1:0] word
  );
    logic [DATA_WIDTH-1:0] sh_b;
    logic [DATA_WIDTH-1:0] sh_h;
    sh_b = word >> {addr_lo, 3'b000};
    sh_h = word >> {addr_lo[1], 4'b0000};
    case (funct3)
      3'b000:  align_load = {{(DATA_WIDTH-8){sh_b[7]}}, sh_b[7:0]};
      3'b100:  align_load = {{(DATA_WIDTH-8){1'b0}}, sh_b[7:0]};
      3'b001:  align_load = {{(DATA_WIDTH-16){sh_h[15]}}, sh_h[15:0]};
      3'b101:  align_load = {{(DATA_WIDTH-16){1'b0}}, sh_h[15:0]};
      default: align_load = word;
    endcase
  endfunction

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    halted   = 1'b0;
    case (state_q)
      RUN: begin
        in_ready = 1'b1;
        if (in_valid && in_ebreak) state_d = HALT;
      end
      HALT: halted = 1'b1;
      default: state_d = RUN;
    endcase
  end

  assign transfer = in_valid & in_ready;
  assign result   = in_is_load ? align_load(in_funct3, in_addr_lo, in_load_word)
                               : in_alu_result;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= RUN;
    else          state_q <= state_d;
  end

  // NOTE: the stage register is a handful of flops, so all of it is reset; outputs read 0 out of reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      full_q <= 1'b0;
      rd_q   <= '0;
      wen_q  <= 1'b0;
      data_q <= '0;
    end else if (transfer) begin
      full_q <= 1'b1;
      rd_q   <= in_rd;
      wen_q  <= in_wen;
      data_q <= result;
    end else begin
      full_q <= 1'b0;
    end
  end

  // Every occupied cycle is one retirement, including non-writing instructions.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    retire_q <= '0;
    else if (full_q) retire_q <= retire_q + 32'd1;
  end

  assign rf_valid   = full_q;
  assign rf_wen     = wen_q;
  assign rf_waddr   = rd_q;
  assign rf_wdata   = data_q;
  assign retire_cnt = retire_q;

`ifdef YSYX_23060236_WBU_FWD_EN
  assign fwd_valid = full_q & wen_q & (rd_q != '0);
  assign fwd_addr  = rd_q;
  assign fwd_data  = data_q;
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_ysyx_23060236_wbu.sv
// Self-checking bench for ysyx_23060236_wbu: directed cases plus a randomized stream
// compared against a behavioural model of the writeback stage.
module tb_ysyx_23060236_wbu;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_rd = '0;
  logic        in_wen = 1'b0;
  logic        in_is_load = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [1:0]  in_addr_lo = '0;
  logic [31:0] in_alu_result = '0;
  logic [31:0] in_load_word = '0;
  logic        in_ebreak = 1'b0;
  logic [31:0] rf_wdata;
  logic [3:0]  rf_waddr;
  logic        rf_wen;
  logic        rf_valid;
  logic [31:0] retire_cnt;
  logic        halted;
  logic        fwd_valid;
  logic [3:0]  fwd_addr;
  logic [31:0] fwd_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit          m_full;
  bit [3:0]    m_rd;
  bit          m_wen;
  bit [31:0]   m_data;
  bit [31:0]   m_cnt;
  bit          m_halt;

  ysyx_23060236_wbu #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_wen(in_wen), .in_is_load(in_is_load),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .in_alu_result(in_alu_result), .in_load_word(in_load_word),
    .in_ebreak(in_ebreak),
    .rf_wdata(rf_wdata), .rf_waddr(rf_waddr), .rf_wen(rf_wen), .rf_valid(rf_valid),
    .retire_cnt(retire_cnt), .halted(halted),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
  );

  always #5 clock = ~clock;

  // Expected writeback value from the ISA load rules, using plain arithmetic.
  function automatic bit [31:0] ref_data(bit is_load, bit [2:0] f3, bit [1:0] lo,
                                         bit [31:0] alu, bit [31:0] word);
    bit [31:0] v;
    if (!is_load) return alu;
    case (f3[1:0])
      2'd0: begin
        v = (word / (32'd1 << (8 * lo))) % 32'd256;
        if (!f3[2] && v >= 32'd128) v = v - 32'd256;
      end
      2'd1: begin
        v = (word / (32'd1 << (16 * lo[1]))) % 32'd65536;
        if (!f3[2] && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    m_full = 0; m_rd = 0; m_wen = 0; m_data = 0; m_cnt = 0; m_halt = 0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  // Drive one cycle of stimulus, advance the model at the edge, settle #1 after.
  task automatic cycle(input bit v, input bit [3:0] rd, input bit wen, input bit ld,
                       input bit [2:0] f3, input bit [1:0] lo, input bit [31:0] alu,
                       input bit [31:0] word, input bit eb);
    in_valid = v; in_rd = rd; in_wen = wen; in_is_load = ld; in_funct3 = f3;
    in_addr_lo = lo; in_alu_result = alu; in_load_word = word; in_ebreak = eb;
    @(posedge clock);
    if (m_full) m_cnt = m_cnt + 1;
    if (v && !m_halt) begin
      m_full = 1; m_rd = rd; m_wen = wen; m_data = ref_data(ld, f3, lo, alu, word);
      if (eb) m_halt = 1;
    end else begin
      m_full = 0;
    end
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (rf_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rf_valid got %b want 0", rf_valid); end
    n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL reset_rf_wen got %b want 0", rf_wen); end
    n_checks++; if (rf_waddr !== 4'd0 || rf_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_rf_data got %h/%h want 0/0", rf_waddr, rf_wdata); end
    n_checks++; if (retire_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_retire got %0d want 0", retire_cnt); end
    n_checks++; if (halted !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ctrl got halted=%b ready=%b want 0/1", halted, in_ready); end
    n_checks++; if (fwd_valid !== 1'b0 || fwd_addr !== 4'd0 || fwd_data !== 32'd0) begin n_fail++; $display("FAIL reset_fwd got %b/%h/%h want 0", fwd_valid, fwd_addr, fwd_data); end
  endtask

  task automatic test_alu_write();
    do_reset();
    cycle(1, 4'd5, 1, 0, 3'b000, 2'd0, 32'h1234, 32'hDEADBEEF, 0);
    n_checks++; if (rf_valid !== 1'b1 || rf_wen !== 1'b1) begin n_fail++; $display("FAIL alu_valid got %b/%b want 1/1", rf_valid, rf_wen); end
    n_checks++; if (rf_waddr !== 4'd5) begin n_fail++; $display("FAIL alu_waddr got %0d want 5", rf_waddr); end
    n_checks++; if (rf_wdata !== 32'h1234) begin n_fail++; $display("FAIL alu_wdata got %h want 00001234", rf_wdata); end
    n_checks++; if (retire_cnt !== 32'd0) begin n_fail++; $display("FAIL alu_retire_early got %0d want 0", retire_cnt); end
    idle();
    n_checks++; if (retire_cnt !== 32'd1 || rf_valid !== 1'b0) begin n_fail++; $display("FAIL alu_retire got %0d/%b want 1/0", retire_cnt, rf_valid); end
  endtask

  task automatic test_loads();
    bit [31:0] w;
    w = 32'h80FF7F01;
    cycle(1, 4'd1, 1, 1, 3'b000, 2'd3, 32'h0, w, 0);
    n_checks++; if (rf_wdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb got %h want FFFFFF80", rf_wdata); end
    cycle(1, 4'd2, 1, 1, 3'b100, 2'd2, 32'h0, w, 0);
    n_checks++; if (rf_wdata !== 32'h000000FF) begin n_fail++; $display("FAIL lbu got %h want 000000FF", rf_wdata); end
    cycle(1, 4'd3, 1, 1, 3'b001, 2'd2, 32'h0, w, 0);
    n_checks++; if (rf_wdata !== 32'hFFFF80FF) begin n_fail++; $display("FAIL lh got %h want FFFF80FF", rf_wdata); end
    cycle(1, 4'd4, 1, 1, 3'b101, 2'd0, 32'h0, w, 0);
    n_checks++; if (rf_wdata !== 32'h00007F01) begin n_fail++; $display("FAIL lhu got %h want 00007F01", rf_wdata); end
    cycle(1, 4'd6, 1, 1, 3'b010, 2'd1, 32'h0, w, 0);
    n_checks++; if (rf_wdata !== w) begin n_fail++; $display("FAIL lw got %h want %h", rf_wdata, w); end
    cycle(1, 4'd7, 1, 1, 3'b000, 2'd1, 32'h0, w, 0);
    n_checks++; if (rf_wdata !== 32'h0000007F) begin n_fail++; $display("FAIL lb_pos got %h want 0000007F", rf_wdata); end
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1, 4'(i + 8), 1, 0, 3'b000, 2'd0, 32'hA000 + 32'(i), 32'h0, 0);
      n_checks++; if (rf_valid !== 1'b1 || rf_wdata !== 32'hA000 + 32'(i)) begin n_fail++; $display("FAIL b2b_%0d got %b/%h want 1/%h", i, rf_valid, rf_wdata, 32'hA000 + 32'(i)); end
    end
    idle();
    n_checks++; if (retire_cnt !== 32'd4) begin n_fail++; $display("FAIL b2b_retire got %0d want 4", retire_cnt); end
  endtask

  task automatic test_forward();
    bit exp_v;
    cycle(1, 4'd0, 1, 0, 3'b000, 2'd0, 32'h55, 32'h0, 0);
    n_checks++; if (fwd_valid !== 1'b0) begin n_fail++; $display("FAIL fwd_rd0 got %b want 0", fwd_valid); end
    cycle(1, 4'd3, 1, 0, 3'b000, 2'd0, 32'h77, 32'h0, 0);
`ifdef YSYX_23060236_WBU_FWD_EN
    exp_v = 1'b1;
    n_checks++; if (fwd_data !== 32'h77 || fwd_addr !== 4'd3) begin n_fail++; $display("FAIL fwd_rd3_data got %h/%h want 3/00000077", fwd_addr, fwd_data); end
`else
    exp_v = 1'b0;
`endif
    n_checks++; if (fwd_valid !== exp_v) begin n_fail++; $display("FAIL fwd_rd3 got %b want %b", fwd_valid, exp_v); end
    idle();
  endtask

  task automatic test_random();
    bit v, wen, ld, ev;
    bit [3:0] rd;
    bit [2:0] f3;
    bit [1:0] lo;
    for (int i = 0; i < 300; i++) begin
      v = ($urandom % 4) != 0; wen = $urandom % 2; ld = $urandom % 2;
      rd = 4'($urandom); f3 = 3'($urandom); lo = 2'($urandom);
      cycle(v, rd, wen, ld, f3, lo, $urandom, $urandom, 0);
      n_checks++; if (rf_valid !== m_full || retire_cnt !== m_cnt || in_ready !== 1'b1) begin n_fail++; $display("FAIL rand_ctrl[%0d] got v=%b cnt=%0d rdy=%b want %b/%0d/1", i, rf_valid, retire_cnt, in_ready, m_full, m_cnt); end
      if (m_full) begin
        n_checks++; if (rf_wen !== m_wen || rf_waddr !== m_rd || rf_wdata !== m_data) begin n_fail++; $display("FAIL rand_data[%0d] got %b/%h/%h want %b/%h/%h", i, rf_wen, rf_waddr, rf_wdata, m_wen, m_rd, m_data); end
      end
`ifdef YSYX_23060236_WBU_FWD_EN
      ev = m_full && m_wen && (m_rd != 0);
      if (ev) begin
        n_checks++; if (fwd_addr !== m_rd || fwd_data !== m_data) begin n_fail++; $display("FAIL rand_fwd_data[%0d] got %h/%h want %h/%h", i, fwd_addr, fwd_data, m_rd, m_data); end
      end
`else
      ev = 1'b0;
`endif
      n_checks++; if (fwd_valid !== ev) begin n_fail++; $display("FAIL rand_fwd[%0d] got %b want %b", i, fwd_valid, ev); end
    end
    idle();
    n_checks++; if (retire_cnt !== m_cnt) begin n_fail++; $display("FAIL rand_retire got %0d want %0d", retire_cnt, m_cnt); end
  endtask

  task automatic test_reset_mid();
    cycle(1, 4'd9, 1, 0, 3'b000, 2'd0, 32'hCAFE, 32'h0, 0);
    reset_n = 1'b0;
    #2;
    n_checks++; if (rf_valid !== 1'b0 || rf_wen !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b/%b want 0/0", rf_valid, rf_wen); end
    n_checks++; if (rf_wdata !== 32'd0 || rf_waddr !== 4'd0 || retire_cnt !== 32'd0) begin n_fail++; $display("FAIL rstmid_data got %h/%h/%0d want 0", rf_wdata, rf_waddr, retire_cnt); end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();
    idle();
    n_checks++; if (rf_valid !== 1'b0 || retire_cnt !== 32'd0) begin n_fail++; $display("FAIL rstmid_after got %b/%0d want 0/0", rf_valid, retire_cnt); end
  endtask

  task automatic test_ebreak();
    do_reset();
    cycle(1, 4'd2, 1, 0, 3'b000, 2'd0, 32'h11, 32'h0, 0);
    cycle(1, 4'd7, 1, 0, 3'b000, 2'd0, 32'hEB, 32'h0, 1);
    n_checks++; if (rf_valid !== 1'b1 || rf_wdata !== 32'hEB) begin n_fail++; $display("FAIL ebreak_entry got %b/%h want 1/000000EB", rf_valid, rf_wdata); end
    n_checks++; if (halted !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL ebreak_halt got %b/%b want 1/0", halted, in_ready); end
    for (int i = 0; i < 5; i++) begin
      cycle(1, 4'd4, 1, 0, 3'b000, 2'd0, $urandom, 32'h0, $urandom % 2);
      n_checks++; if (rf_valid !== 1'b0 || retire_cnt !== 32'd2 || halted !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL halt_hold[%0d] got v=%b cnt=%0d h=%b r=%b want 0/2/1/0", i, rf_valid, retire_cnt, halted, in_ready); end
    end
    n_checks++; if (retire_cnt !== m_cnt) begin n_fail++; $display("FAIL halt_model got %0d want %0d", retire_cnt, m_cnt); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_alu_write();
    test_loads();
    test_back_to_back();
    test_forward();
    test_random();
    test_reset_mid();
    test_ebreak();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
